// File: rtl/usb_tx_bitstream.sv
// USB transmit bit serializer: SYNC, LSB-first payload with bit stuffing, multi-cycle EOP.
// Latency: first SYNC bit (with NRZ_start) in the cycle after data_valid is seen in IDLE; one bit per unstalled cycle.
// Backpressure: stop_stream freezes all state and masks handshake/pulse outputs; data_ready is asserted only on word boundaries.
module usb_tx_bitstream #(
    parameter int                DATA_W       = 8,
    parameter int                SYNC_W       = 8,
    parameter logic [SYNC_W-1:0] SYNC_PATTERN = 8'h80,
    parameter int                STUFF_RUN    = 6,
    parameter int                EOP_CYCLES   = 2
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    input  logic              data_last,
    output logic              data_ready,
    input  logic              stop_stream,
    output logic              bit_out,
    output logic              bit_valid,
    output logic              eop,
    output logic              NRZ_start,
    output logic              stream_begin,
    output logic              stream_done,
    output logic              underrun
);

    localparam int CNT_MAX = (DATA_W > SYNC_W) ? DATA_W : SYNC_W;
    localparam int CW      = $clog2(CNT_MAX);
    localparam int RW      = $clog2(STUFF_RUN + 1);
    localparam int EW      = (EOP_CYCLES > 1) ? $clog2(EOP_CYCLES) : 1;

    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_STUFF, S_EOP} state_t;

    state_t            state;
    state_t            pend_state;
    logic              pend_bit;
    logic              pend_begin;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] shift;
    logic              last_r;
    logic [RW-1:0]     run;
    logic [EW-1:0]     ecnt;
    logic              bit_out_r;
    logic              bit_valid_r;
    logic              eop_r;
    logic              nrz_start_r;
    logic              stream_begin_r;
    logic              stream_done_r;
    logic              underrun_r;

    // Advance decision: where the serializer goes after the bit currently on the wire.
    logic              sync_end;
    logic              data_end;
    logic              boundary;
    logic              need_stuff;
    logic              go_eop;
    logic [RW-1:0]     run_inc;
    logic [CW-1:0]     cnt_inc;
    state_t            adv_state;
    logic              adv_bit;
    logic              adv_begin;
    logic              adv_load;
    logic              adv_underrun;
    logic [CW-1:0]     adv_cnt;
    logic [DATA_W-1:0] adv_shift;

    // Compute next emitted bit, word loads, stuffing need and EOP entry from the current position.
    always_comb begin
        sync_end     = (state == S_SYNC) && (cnt == CW'(SYNC_W - 1));
        data_end     = (state == S_DATA) && (cnt == CW'(DATA_W - 1));
        boundary     = sync_end || (data_end && !last_r);
        run_inc      = run + RW'(1);
        cnt_inc      = cnt + CW'(1);
        need_stuff   = ((state == S_SYNC) || (state == S_DATA)) && bit_out_r
                       && (run_inc == RW'(STUFF_RUN));
        adv_state    = state;
        adv_bit      = 1'b0;
        adv_begin    = 1'b0;
        adv_load     = 1'b0;
        adv_underrun = 1'b0;
        adv_cnt      = cnt;
        adv_shift    = shift;
        if (boundary) begin
            if (data_valid) begin
                adv_load  = 1'b1;
                adv_state = S_DATA;
                adv_cnt   = '0;
                adv_shift = data_in;
                adv_bit   = data_in[0];
                adv_begin = sync_end;
            end else begin
                adv_state    = S_EOP;
                adv_underrun = 1'b1;
            end
        end else if (state == S_SYNC) begin
            adv_cnt = cnt_inc;
            adv_bit = SYNC_PATTERN[cnt_inc];
        end else if (state == S_DATA) begin
            if (data_end) begin
                adv_state = S_EOP;
            end else begin
                adv_cnt   = cnt_inc;
                adv_shift = shift >> 1;
                adv_bit   = shift[1];
            end
        end
        go_eop = 1'b0;
        if ((state == S_SYNC) || (state == S_DATA)) begin
            go_eop = adv_underrun || ((adv_state == S_EOP) && !need_stuff);
        end else if (state == S_STUFF) begin
            go_eop = (pend_state == S_EOP);
        end
    end

    // Main FSM: state, counters and all registered outputs; everything holds while stalled.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state          <= S_IDLE;
            pend_state     <= S_IDLE;
            pend_bit       <= 1'b0;
            pend_begin     <= 1'b0;
            cnt            <= '0;
            shift          <= '0;
            last_r         <= 1'b0;
            run            <= '0;
            ecnt           <= '0;
            bit_out_r      <= 1'b0;
            bit_valid_r    <= 1'b0;
            eop_r          <= 1'b0;
            nrz_start_r    <= 1'b0;
            stream_begin_r <= 1'b0;
            stream_done_r  <= 1'b0;
            underrun_r     <= 1'b0;
        end else if (!stop_stream) begin
            nrz_start_r    <= 1'b0;
            stream_begin_r <= 1'b0;
            stream_done_r  <= 1'b0;
            underrun_r     <= 1'b0;
            if ((state == S_SYNC) || (state == S_DATA)) begin
                cnt   <= adv_cnt;
                shift <= adv_shift;
                if (adv_load) begin
                    last_r <= data_last;
                end
            end
            if (go_eop) begin
                // Underrun aborts straight to EOP; any owed stuff bit is dropped with the packet.
                state         <= S_EOP;
                eop_r         <= 1'b1;
                bit_valid_r   <= 1'b0;
                bit_out_r     <= 1'b0;
                stream_done_r <= 1'b1;
                underrun_r    <= adv_underrun;
                ecnt          <= '0;
                run           <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (data_valid) begin
                            state       <= S_SYNC;
                            cnt         <= '0;
                            run         <= '0;
                            last_r      <= 1'b0;
                            bit_out_r   <= SYNC_PATTERN[0];
                            bit_valid_r <= 1'b1;
                            nrz_start_r <= 1'b1;
                        end
                    end
                    S_SYNC, S_DATA: begin
                        if (need_stuff) begin
                            // Position already advanced; the real next bit waits one cycle behind the stuffed 0.
                            state       <= S_STUFF;
                            bit_out_r   <= 1'b0;
                            bit_valid_r <= 1'b1;
                            run         <= '0;
                            pend_state  <= adv_state;
                            pend_bit    <= adv_bit;
                            pend_begin  <= adv_begin;
                        end else begin
                            state          <= adv_state;
                            bit_out_r      <= adv_bit;
                            bit_valid_r    <= 1'b1;
                            stream_begin_r <= adv_begin;
                            run            <= bit_out_r ? run_inc : '0;
                        end
                    end
                    S_STUFF: begin
                        state          <= pend_state;
                        bit_out_r      <= pend_bit;
                        bit_valid_r    <= 1'b1;
                        stream_begin_r <= pend_begin;
                    end
                    S_EOP: begin
                        if (ecnt == EW'(EOP_CYCLES - 1)) begin
                            state <= S_IDLE;
                            eop_r <= 1'b0;
                            ecnt  <= '0;
                        end else begin
                            ecnt <= ecnt + EW'(1);
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bit_out      = bit_out_r;
    assign eop          = eop_r;
    assign bit_valid    = bit_valid_r & ~stop_stream;
    assign NRZ_start    = nrz_start_r & ~stop_stream;
    assign stream_begin = stream_begin_r & ~stop_stream;
    assign stream_done  = stream_done_r & ~stop_stream;
    assign underrun     = underrun_r & ~stop_stream;
    assign data_ready   = boundary & ~stop_stream;

endmodule

// File: tb/tb_usb_tx_bitstream.sv
// Scoreboard bench for usb_tx_bitstream: directed packets push hand-computed bit streams,
// a monitor pops and compares every valid bit and tallies pulses for per-packet checks.
// Stimulus holds data_valid until data_ready, then drops it (or withholds a word for underrun).
module tb_usb_tx_bitstream;

    logic       clk = 1'b0;
    logic       rst_b;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_last;
    logic       data_ready;
    logic       stop_stream;
    logic       bit_out;
    logic       bit_valid;
    logic       eop;
    logic       NRZ_start;
    logic       stream_begin;
    logic       stream_done;
    logic       underrun;

    always #5 clk = ~clk;

    usb_tx_bitstream dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .data_last    (data_last),
        .data_ready   (data_ready),
        .stop_stream  (stop_stream),
        .bit_out      (bit_out),
        .bit_valid    (bit_valid),
        .eop          (eop),
        .NRZ_start    (NRZ_start),
        .stream_begin (stream_begin),
        .stream_done  (stream_done),
        .underrun     (underrun)
    );

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic exp_q[$];
    logic mon_exp;
    int   bits_seen  = 0;
    int   eop_seen   = 0;
    int   done_seen  = 0;
    int   nrz_seen   = 0;
    int   begin_seen = 0;
    int   under_seen = 0;
    int   rdy_seen   = 0;
    int   done_cyc   = 0;
    int   nrz_cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] outs();
        return {bit_out, bit_valid, eop, NRZ_start, stream_begin, stream_done, underrun, data_ready};
    endfunction

    task automatic run_pkt(input string nm, input int nw, input int provide,
                           input logic [7:0] w0, input logic [7:0] w1,
                           input logic [63:0] eb, input int elen,
                           input int erdy, input int eund, input int stall);
        int s_bits  = bits_seen;
        int s_eop   = eop_seen;
        int s_done  = done_seen;
        int s_nrz   = nrz_seen;
        int s_begin = begin_seen;
        int s_under = under_seen;
        int s_rdy   = rdy_seen;
        int start   = cyc;
        int guard;
        for (int i = 0; i < elen; i++) exp_q.push_back(eb[i]);
        for (int i = 0; i < provide; i++) begin
            data_in    = (i == 0) ? w0 : w1;
            data_last  = (i == nw - 1);
            data_valid = 1'b1;
            guard = 0;
            do begin
                @(negedge clk);
                guard++;
            end while (!data_ready && guard < 100);
            if (!data_ready) chk({nm, "_ready_timeout"}, 0, 1);
            @(posedge clk);
            #1;
        end
        data_valid = 1'b0;
        data_last  = 1'b0;
        data_in    = '0;
        if (stall > 0) begin
            repeat (3) @(posedge clk);
            #1;
            stop_stream = 1'b1;
            repeat (stall) begin
                @(negedge clk);
                chk({nm, "_stall_bit_valid"}, bit_valid, 0);
            end
            @(posedge clk);
            #1;
            stop_stream = 1'b0;
        end
        guard = 0;
        do begin
            @(negedge clk);
            #1;
            guard++;
        end while (!((eop_seen - s_eop) >= 2 && !eop) && guard < 300);
        chk({nm, "_finish_in_time"}, (guard < 300), 1);
        chk({nm, "_bit_count"}, bits_seen - s_bits, elen);
        chk({nm, "_queue_empty"}, exp_q.size(), 0);
        chk({nm, "_eop_cycles"}, eop_seen - s_eop, 2);
        chk({nm, "_stream_done"}, done_seen - s_done, 1);
        chk({nm, "_nrz_start"}, nrz_seen - s_nrz, 1);
        chk({nm, "_stream_begin"}, begin_seen - s_begin, 1);
        chk({nm, "_underrun"}, under_seen - s_under, eund);
        chk({nm, "_data_ready"}, rdy_seen - s_rdy, erdy);
        chk({nm, "_nrz_latency"}, nrz_cyc - start, 1);
        chk({nm, "_done_latency"}, done_cyc - start, elen + 1 + stall);
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int s_bits;
        int s_done;
        int guard;
        fork
            forever begin
                @(negedge clk);
                if (bit_valid) begin
                    bits_seen++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_bit", 1, 0);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        chk($sformatf("bit_%0d", bits_seen), bit_out, mon_exp);
                    end
                end
                if (eop) eop_seen++;
                if (stream_done) begin done_seen++; done_cyc = cyc; end
                if (NRZ_start) begin nrz_seen++; nrz_cyc = cyc; end
                if (stream_begin) begin_seen++;
                if (underrun) under_seen++;
                if (data_ready) rdy_seen++;
            end
        join_none

        rst_b       = 1'b0;
        data_in     = '0;
        data_valid  = 1'b0;
        data_last   = 1'b0;
        stop_stream = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", outs(), 0);
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_outputs", outs(), 0);

        // SYNC 0000_0001 then eight 0s.
        run_pkt("single_00", 1, 1, 8'h00, 8'h00, 64'h0080, 16, 1, 0, 0);
        // SYNC, 1x5, stuffed 0, 1x3.
        run_pkt("single_ff", 1, 1, 8'hFF, 8'h00, 64'h1DF80, 17, 1, 0, 0);
        // Stuffs after data bits 5 and 11, run of 5 at the end needs no stuff.
        run_pkt("two_ff", 2, 2, 8'hFF, 8'hFF, 64'h3EFDF80, 26, 2, 0, 0);
        // 0,0,1x6 then a trailing stuffed 0 before EOP.
        run_pkt("trail_stuff", 1, 1, 8'hFC, 8'h00, 64'hFC80, 17, 1, 0, 0);
        // Second word withheld at its data_ready.
        run_pkt("underrun", 2, 1, 8'h00, 8'h00, 64'h0080, 16, 2, 1, 0);
        // 0xA5 LSB-first 1,0,1,0,0,1,0,1 with a 3-cycle stall mid-DATA.
        run_pkt("stall_a5", 1, 1, 8'hA5, 8'h00, 64'hA580, 16, 1, 0, 3);

        // Reset in the middle of SYNC.
        s_bits = bits_seen;
        s_done = done_seen;
        for (int i = 0; i < 16; i++) exp_q.push_back(i == 7);
        data_in    = 8'h00;
        data_last  = 1'b1;
        data_valid = 1'b1;
        guard = 0;
        do begin
            @(negedge clk);
            #1;
            guard++;
        end while ((bits_seen - s_bits) < 3 && guard < 50);
        chk("rst_reach_sync", (guard < 50), 1);
        rst_b      = 1'b0;
        data_valid = 1'b0;
        data_last  = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_sync_outputs", outs(), 0);
        exp_q.delete();
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_then_idle", outs(), 0);
        repeat (4) @(posedge clk);
        #1;
        chk("rst_no_more_bits", bits_seen - s_bits, 3);
        chk("rst_no_stream_done", done_seen - s_done, 0);

        run_pkt("post_reset", 1, 1, 8'h3C, 8'h00, 64'h3C80, 16, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
